keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Matrix-keypad front end for the door-lock datapath. It sits directly upstream of the digit-shift keypad register and the lock controller. It scans a 4x3 switch matrix, debounces it, and rejects multi-key ghosts. Each accepted press becomes a single-cycle `pressed` pulse with a BCD digit on `key` (always 0..9), and `*` becomes a single-cycle `set_code` pulse, so the downstream lock receives clean events.

## Interface
- `SCAN_CYCLES`, default 4: clock cycles each row is driven. Legal values are 3 or more; elaboration fails otherwise.
- `DEBOUNCE`, default 8: consecutive identical scan frames required to accept a press or a release. Legal range is 2..255.
- `clk`, input, 1: system clock. The block uses one clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `row_n`, output, 4: active-low row drive. Exactly one bit is low at any time.
- `col_n`, input, 3: active-low column sense. It is asynchronous and is synchronized internally.
- `key`, output, 4: last accepted digit, 0..9, held between events.
- `pressed`, output, 1: one-cycle pulse for each accepted digit press.
- `set_code`, output, 1: one-cycle pulse for each accepted `*` press.

## Operation
- **Synchronizer:** `col_n` passes through 2 flops before use.
- **Scanner:**
  - A row index 0..3 drives `row_n[idx]` low for SCAN_CYCLES cycles, then advances, wrapping 3 to 0.
  - Synchronized columns are sampled on the last dwell cycle of each row.
  - One frame is 4*SCAN_CYCLES cycles.
- **Key map** (rows 0..3, cols 0..2):
  - Row 0: 1 2 3
  - Row 1: 4 5 6
  - Row 2: 7 8 9
  - Row 3: * 0 #
  - Codes: digits use their own value, `*` = 10, `#` = 11.
- **Frame result**, computed at the end of each frame:
  - NONE: no closure.
  - SINGLE(code): exactly one closure.
  - MULTI: two or more closures.
- **Debounce FSM** (evaluated once per frame end):
  - IDLE: SINGLE(c) sets cand=c, cnt=1, and moves to QUAL. Anything else stays in IDLE.
  - QUAL:
    - SINGLE(cand) increments cnt. When cnt reaches DEBOUNCE, emit cand and move to HELD.
    - Any other result moves to IDLE.
  - HELD:
    - NONE sets cnt=1 and moves to REL.
    - SINGLE(any code) or MULTI stays in HELD. There is no rollover.
  - REL:
    - NONE increments cnt. When cnt reaches DEBOUNCE, move to IDLE.
    - Any other result sets cnt=0 and returns to HELD.
- **Emit rules:**
  - Digit d: `pressed`=1 and `key`=d in the same cycle.
  - `*`: `set_code`=1. `pressed` stays 0 and `key` is unchanged.
  - `#`: reserved. No output and no key change; the FSM still goes through HELD and REL.
- **Output invariants:**
  - `pressed` and `set_code` are never high together.
  - `key` is always below 10.
  - Exactly one event per physical press, however long the key is held.

## Timing
- **Reset values:** `row_n`=4'b1110, `key`=0, `pressed`=0, `set_code`=0. FSM in IDLE, all counters 0, synchronizer flops reset to 3'b111.
- **Pulse timing:** the pulse is registered and appears in the cycle after the qualifying frame end. It is deasserted in the following cycle.
- **Press latency:** from a stable closure to the pulse is at most (DEBOUNCE+1) frames + 3 cycles.
- **Release:** needs DEBOUNCE clean frames before the next press can qualify.
- **Sampling margin:** SCAN_CYCLES ≥ 3 guarantees the sampled columns belong to the row currently driven, because the 2-cycle synchronizer delay settles within the dwell.
- **Reset mid-operation:** all state clears and any pending pulse is dropped. A key still held when `rst` falls is re-qualified from IDLE and produces one new event.
- **Counter width:** `cnt` saturates and never wraps.

## Structure
- **Package `keypad_pkg`:**
  - Constants: KEY_STAR=10, KEY_HASH=11, ROWS=4, COLS=3.
  - Frame-result typedef: NONE, SINGLE, MULTI.
  - FSM state enum: IDLE, QUAL, HELD, REL.
  - Key-map function from (row, col) to code.
- **Sub-module `keypad_debounce`:** the FSM plus the emit logic. Inputs are a frame-valid strobe, the frame result and the code; outputs are `key`, `pressed` and `set_code`.
- **Top `keypad_scanner`:** holds the synchronizer, row counter and frame accumulator.

## Test plan
All scenarios use DEBOUNCE=8 and SCAN_CYCLES=4.
- **Idle scan:** reset, then no keys for 3 frames. `row_n` steps 1110, 1101, 1011, 0111 with 4 cycles per row. `pressed` and `set_code` stay 0.
- **Single press:** hold `5` (row 1, col 1) for 20 frames, then release. Exactly one `pressed` pulse with `key`=5. `key` stays 5 after release.
- **Bounce:** toggle `7` every frame for 6 frames, then hold it stable. No pulse during the bounce. One pulse with `key`=7 within 9 frames + 3 cycles of becoming stable.
- **Set code:** hold `*` for 15 frames. One `set_code` pulse, `pressed` stays 0, `key` is unchanged. Holding `#` produces no output at all.
- **Ghost rejection:** hold `1` and `2` together for 10 frames, which produces no event. Then release `2` while keeping `1`. One pulse with `key`=1.
- **Reset mid-hold and lock sequence:**
  - Hold `9` in HELD, assert `rst` for 1 cycle. All outputs are 0 on the next cycle; after reset, one new pulse with `key`=9.
  - Then press 1, 2, 3, 4, `*`, 1, 2, 3, 4. Exactly 8 `pressed` pulses and 1 `set_code` pulse, in that order.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants, types and key map for the matrix keypad front end.
package keypad_pkg;

   localparam int unsigned ROWS = 4;
   localparam int unsigned COLS = 3;
   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_HASH = 4'd11;

   typedef enum logic [1:0] {FrNone, FrSingle, FrMulti} frame_res_e;

   typedef enum logic [1:0] {StIdle, StQual, StHeld, StRel} db_state_e;

   // Rows 0..2 carry digits 1..9; row 3 is "* 0 #".
   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      if (row != 2'd3) begin
         code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
      end else begin
         case (col)
            2'd0:    code = KEY_STAR;
            2'd1:    code = 4'd0;
            default: code = KEY_HASH;
         endcase
      end
      return code;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-rate debounce FSM; turns qualified frame results into single-cycle events.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       frame_valid_i,
   input  frame_res_e frame_res_i,
   input  logic [3:0] frame_code_i,
   output logic [3:0] key_o,
   output logic       pressed_o,
   output logic       set_code_o
);

   if (DEBOUNCE < 2 || DEBOUNCE > 255) begin : g_bad_debounce
      $error("DEBOUNCE must be in 2..255");
   end

   localparam logic [7:0] DbLimit = 8'(DEBOUNCE);

   db_state_e  state_q, state_d;
   logic [7:0] cnt_q, cnt_d, cnt_inc;
   logic [3:0] cand_q, cand_d;
   logic [3:0] key_q, key_d;
   logic       pressed_q, pressed_d;
   logic       set_code_q, set_code_d;
   logic       emit;

   assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cand_d     = cand_q;
      key_d      = key_q;
      pressed_d  = 1'b0;
      set_code_d = 1'b0;
      emit       = 1'b0;
      if (frame_valid_i) begin
         unique case (state_q)
            StIdle: begin
               if (frame_res_i == FrSingle) begin
                  cand_d  = frame_code_i;
                  cnt_d   = 8'd1;
                  state_d = StQual;
               end
            end
            StQual: begin
               if (frame_res_i == FrSingle && frame_code_i == cand_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == DbLimit) begin
                     emit    = 1'b1;
                     state_d = StHeld;
                  end
               end else begin
                  state_d = StIdle;
               end
            end
            StHeld: begin
               if (frame_res_i == FrNone) begin
                  cnt_d   = 8'd1;
                  state_d = StRel;
               end
            end
            StRel: begin
               if (frame_res_i == FrNone) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == DbLimit) state_d = StIdle;
               end else begin
                  cnt_d   = 8'd0;
                  state_d = StHeld;
               end
            end
            default: state_d = StIdle;
         endcase
      end
      // '#' qualifies like any key but is deliberately silent.
      if (emit) begin
         if (cand_q < KEY_STAR) begin
            pressed_d = 1'b1;
            key_d     = cand_q;
         end else if (cand_q == KEY_STAR) begin
            set_code_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         cnt_q      <= 8'd0;
         cand_q     <= 4'd0;
         key_q      <= 4'd0;
         pressed_q  <= 1'b0;
         set_code_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cand_q     <= cand_d;
         key_q      <= key_d;
         pressed_q  <= pressed_d;
         set_code_q <= set_code_d;
      end
   end

   assign key_o      = key_q;
   assign pressed_o  = pressed_q;
   assign set_code_o = set_code_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: column synchronizer, row sweep and per-frame closure accumulator.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_CYCLES = 4,
   parameter int unsigned DEBOUNCE    = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   output logic [ROWS-1:0] row_n_o,
   input  logic [COLS-1:0] col_n_i,
   output logic [3:0]      key_o,
   output logic            pressed_o,
   output logic            set_code_o
);

   if (SCAN_CYCLES < 3) begin : g_bad_scan
      $error("SCAN_CYCLES must be at least 3");
   end

   localparam int unsigned DwellW = $clog2(SCAN_CYCLES);
   localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_CYCLES - 1);

   logic [COLS-1:0]   col_s1_q, col_s2_q;
   logic [1:0]        row_q, row_d;
   logic [DwellW-1:0] dwell_q, dwell_d;
   logic [1:0]        acc_cnt_q, acc_cnt_d;
   logic [3:0]        acc_code_q, acc_code_d;

   logic [COLS-1:0] hits;
   logic [1:0]      row_cnt, hit_col, cnt_sat;
   logic [2:0]      cnt_sum;
   logic [3:0]      code_nxt;
   logic            frame_valid;
   frame_res_e      frame_res;

   assign hits    = ~col_s2_q;
   assign row_cnt = 2'(hits[0]) + 2'(hits[1]) + 2'(hits[2]);
   assign hit_col = hits[0] ? 2'd0 : (hits[1] ? 2'd1 : 2'd2);
   assign cnt_sum = {1'b0, acc_cnt_q} + {1'b0, row_cnt};
   assign cnt_sat = (cnt_sum >= 3'd2) ? 2'd2 : cnt_sum[1:0];
   // The code only matters when the whole frame holds exactly one closure.
   assign code_nxt = (acc_cnt_q == 2'd0) ? key_map(row_q, hit_col) : acc_code_q;

   always_comb begin
      row_d       = row_q;
      dwell_d     = dwell_q + DwellW'(1);
      acc_cnt_d   = acc_cnt_q;
      acc_code_d  = acc_code_q;
      frame_valid = 1'b0;
      frame_res   = FrNone;
      if (dwell_q == DwellLast) begin
         dwell_d = '0;
         row_d   = row_q + 2'd1;
         if (row_q == 2'd3) begin
            frame_valid = 1'b1;
            unique case (cnt_sat)
               2'd0:    frame_res = FrNone;
               2'd1:    frame_res = FrSingle;
               default: frame_res = FrMulti;
            endcase
            acc_cnt_d  = 2'd0;
            acc_code_d = 4'd0;
         end else begin
            acc_cnt_d  = cnt_sat;
            acc_code_d = code_nxt;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         col_s1_q   <= '1;
         col_s2_q   <= '1;
         row_q      <= 2'd0;
         dwell_q    <= '0;
         acc_cnt_q  <= 2'd0;
         acc_code_q <= 4'd0;
      end else begin
         col_s1_q   <= col_n_i;
         col_s2_q   <= col_s1_q;
         row_q      <= row_d;
         dwell_q    <= dwell_d;
         acc_cnt_q  <= acc_cnt_d;
         acc_code_q <= acc_code_d;
      end
   end

   assign row_n_o = ~(4'b0001 << row_q);

   keypad_debounce #(
      .DEBOUNCE(DEBOUNCE)
   ) u_debounce (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .frame_valid_i(frame_valid),
      .frame_res_i  (frame_res),
      .frame_code_i (code_nxt),
      .key_o        (key_o),
      .pressed_o    (pressed_o),
      .set_code_o   (set_code_o)
   );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural switch matrix and event log.
module tb_keypad_scanner;

   localparam int Frame = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row_n;
   logic [2:0] col_n;
   logic [3:0] key;
   logic       pressed;
   logic       set_code;

   logic [11:0] keys;   // closed switches, index row*3+col
   int ev_q[$];         // digit for pressed, 10 for set_code
   int n_press, n_set, n_inv_bad;
   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   keypad_scanner dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .row_n_o   (row_n),
      .col_n_i   (col_n),
      .key_o     (key),
      .pressed_o (pressed),
      .set_code_o(set_code)
   );

   always_comb begin
      col_n = 3'b111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (keys[r*3+c] && !row_n[r]) col_n[c] = 1'b0;
   end

   always @(negedge clk) begin
      if (pressed) begin
         ev_q.push_back(int'(key));
         n_press++;
      end
      if (set_code) begin
         ev_q.push_back(10);
         n_set++;
      end
      if ((pressed && set_code) || key >= 4'd10) n_inv_bad++;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int key_idx(input int code);
      if (code >= 1 && code <= 9) return code - 1;
      if (code == 0) return 10;
      if (code == 10) return 9;
      return 11;
   endfunction

   task automatic press(input int code, input int hold_frames, input int rel_frames);
      keys = 12'd0;
      keys[key_idx(code)] = 1'b1;
      step(hold_frames * Frame);
      keys = 12'd0;
      step(rel_frames * Frame);
   endtask

   task automatic clear_log();
      ev_q.delete();
      n_press = 0;
      n_set   = 0;
   endtask

   initial begin
      int exp_seq[9];
      int got;
      rst = 1'b1;
      keys = 12'd0;
      n_press = 0;
      n_set = 0;
      n_inv_bad = 0;
      step(3);
      check("reset key", int'(key), 0);
      check("reset pressed", int'(pressed), 0);
      check("reset set_code", int'(set_code), 0);
      rst = 1'b0;

      // Idle scan: one row per 4 cycles, wrapping after 16.
      for (int k = 0; k <= 16; k++) begin
         check($sformatf("row_n k=%0d", k), int'(row_n), int'(4'b1111 ^ (4'b0001 << ((k / 4) % 4))));
         step(1);
      end
      step(3 * Frame);
      check("idle events", ev_q.size(), 0);

      // Single press of 5 held 20 frames.
      clear_log();
      press(5, 20, 10);
      check("press5 count", n_press, 1);
      check("press5 key", ev_q.size() > 0 ? ev_q[0] : -1, 5);
      check("press5 key held", int'(key), 5);

      // Bounce 7 every frame, then stable.
      clear_log();
      for (int i = 0; i < 6; i++) begin
         keys = (i % 2 == 0) ? 12'd1 << key_idx(7) : 12'd0;
         step(Frame);
      end
      check("bounce no event", ev_q.size(), 0);
      keys = 12'd1 << key_idx(7);
      got = 0;
      for (int i = 0; i < 9 * Frame + 3 && got == 0; i++) begin
         step(1);
         if (pressed) got = 1;
      end
      check("bounce latency", got, 1);
      step(4 * Frame);
      keys = 12'd0;
      step(10 * Frame);
      check("bounce count", n_press, 1);
      check("bounce key", int'(key), 7);

      // Star gives set_code only; hash gives nothing.
      clear_log();
      press(10, 15, 10);
      check("star set_code", n_set, 1);
      check("star no pressed", n_press, 0);
      check("star key kept", int'(key), 7);
      clear_log();
      press(11, 15, 10);
      check("hash silent", ev_q.size(), 0);
      check("hash key kept", int'(key), 7);

      // Ghost: 1 and 2 together, then 1 alone.
      clear_log();
      keys = (12'd1 << key_idx(1)) | (12'd1 << key_idx(2));
      step(10 * Frame);
      check("ghost no event", ev_q.size(), 0);
      keys = 12'd1 << key_idx(1);
      step(12 * Frame);
      keys = 12'd0;
      step(10 * Frame);
      check("ghost then 1 count", n_press, 1);
      check("ghost then 1 key", int'(key), 1);

      // Reset while 9 is held, then re-qualify.
      clear_log();
      keys = 12'd1 << key_idx(9);
      step(12 * Frame);
      check("pre-reset 9", ev_q.size() > 0 ? ev_q[0] : -1, 9);
      clear_log();
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("mid reset key", int'(key), 0);
      check("mid reset pressed", int'(pressed), 0);
      check("mid reset set_code", int'(set_code), 0);
      check("mid reset row_n", int'(row_n), int'(4'b1110));
      step(12 * Frame);
      keys = 12'd0;
      step(10 * Frame);
      check("post reset count", n_press, 1);
      check("post reset key", ev_q.size() > 0 ? ev_q[0] : -1, 9);

      // Lock sequence 1 2 3 4 * 1 2 3 4.
      clear_log();
      exp_seq = '{1, 2, 3, 4, 10, 1, 2, 3, 4};
      for (int i = 0; i < 9; i++) press(exp_seq[i], 10, 10);
      check("lock pressed count", n_press, 8);
      check("lock set_code count", n_set, 1);
      check("lock event count", ev_q.size(), 9);
      for (int i = 0; i < 9; i++)
         check($sformatf("lock ev%0d", i), i < ev_q.size() ? ev_q[i] : -1, exp_seq[i]);

      check("output invariants", n_inv_bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
